// File: rtl/mem_stage.sv
// Memory stage: 256-word data RAM plus memory-mapped timer, LED, seven-segment
// and free-running SYSTICK registers. Loads are combinational; stores commit
// on the rising edge that ends the cycle in which they are presented.
module mem_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_MemRead,
   input  logic        i_MemWr,
   input  logic [31:0] i_Addr,
   input  logic [31:0] i_WriteData,
   output logic [31:0] o_ReadData,
   output logic [7:0]  o_leds,
   output logic [11:0] o_digi,
   output logic        o_IRQ
);

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned RAM_AW   = 8;
   localparam int unsigned RAM_WORDS = 256;
   localparam int unsigned TCON_W   = 3;
   localparam int unsigned LEDS_W   = 8;
   localparam int unsigned DIGI_W   = 12;

   localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
   localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
   localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
   localparam logic [31:0] ADDR_LEDS    = 32'h4000_000C;
   localparam logic [31:0] ADDR_DIGI    = 32'h4000_0010;
   localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

   logic [DATA_W-1:0] ram_q [RAM_WORDS];

   logic [DATA_W-1:0] th_q, th_d;
   logic [DATA_W-1:0] tl_q, tl_d;
   logic [TCON_W-1:0] tcon_q, tcon_d;
   logic [LEDS_W-1:0] leds_q, leds_d;
   logic [DIGI_W-1:0] digi_q, digi_d;
   logic [DATA_W-1:0] systick_q, systick_d;

   logic [29:0]       word_addr;
   logic [RAM_AW-1:0] ram_idx;
   logic              sel_ram, sel_th, sel_tl, sel_tcon, sel_leds, sel_digi, sel_systick;
   logic              unused_addr_lsb;

   // Word-granular address decode; byte offset bits are don't-care
   assign word_addr       = i_Addr[31:2];
   assign ram_idx         = i_Addr[9:2];
   assign unused_addr_lsb = ^i_Addr[1:0];
   assign sel_ram         = (i_Addr[31:10] == 22'd0);
   assign sel_th          = (word_addr == ADDR_TH[31:2]);
   assign sel_tl          = (word_addr == ADDR_TL[31:2]);
   assign sel_tcon        = (word_addr == ADDR_TCON[31:2]);
   assign sel_leds        = (word_addr == ADDR_LEDS[31:2]);
   assign sel_digi        = (word_addr == ADDR_DIGI[31:2]);
   assign sel_systick     = (word_addr == ADDR_SYSTICK[31:2]);

   // Combinational load mux; returns zero when idle or unmapped
   always_comb begin
      o_ReadData = '0;
      if (i_MemRead) begin
         if (sel_ram)          o_ReadData = ram_q[ram_idx];
         else if (sel_th)      o_ReadData = th_q;
         else if (sel_tl)      o_ReadData = tl_q;
         else if (sel_tcon)    o_ReadData = DATA_W'(tcon_q);
         else if (sel_leds)    o_ReadData = DATA_W'(leds_q);
         else if (sel_digi)    o_ReadData = DATA_W'(digi_q);
         else if (sel_systick) o_ReadData = systick_q;
      end
   end

   // RAM write port; contents survive reset, but stores are blocked while reset is high
   always_ff @(posedge clk) begin
      if (!reset && i_MemWr && sel_ram) begin
         ram_q[ram_idx] <= i_WriteData;
      end
   end

   // Next-state: timer/systick advance, then software stores override
   always_comb begin
      th_d      = th_q;
      tl_d      = tl_q;
      tcon_d    = tcon_q;
      leds_d    = leds_q;
      digi_d    = digi_q;
      systick_d = systick_q + 32'd1;

      if (tcon_q[0]) begin
         if (tl_q == 32'hFFFF_FFFF) begin
            tl_d = th_q;
            if (tcon_q[1]) tcon_d[2] = 1'b1;
         end else begin
            tl_d = tl_q + 32'd1;
         end
      end

      if (i_MemWr) begin
         if (sel_th)   th_d   = i_WriteData;
         if (sel_tl)   tl_d   = i_WriteData;
         if (sel_tcon) tcon_d = i_WriteData[TCON_W-1:0];
         if (sel_leds) leds_d = i_WriteData[LEDS_W-1:0];
         if (sel_digi) digi_d = i_WriteData[DIGI_W-1:0];
      end
   end

   // Peripheral register bank with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         th_q      <= '0;
         tl_q      <= '0;
         tcon_q    <= '0;
         leds_q    <= '0;
         digi_q    <= '0;
         systick_q <= '0;
      end else begin
         th_q      <= th_d;
         tl_q      <= tl_d;
         tcon_q    <= tcon_d;
         leds_q    <= leds_d;
         digi_q    <= digi_d;
         systick_q <= systick_d;
      end
   end

   assign o_leds = leds_q;
   assign o_digi = digi_q;
   assign o_IRQ  = tcon_q[1] & tcon_q[2];

endmodule
